toggle_delay_line: RTL and testbench
====================================

# toggle_delay_line

Clocked, parametrised successor to the fixed four-cell request delay chain. It carries CH independent two-phase request channels across a synchronous boundary. Every transition on inR[i] is reproduced on outR[i] after a per-channel programmable number of clock cycles. Up to DEPTH transitions per channel may be in flight at once. It sits where the bundled-data controllers need a matched delay that is tunable at run time instead of fixed at synthesis.

## Interface
- CH, 4: number of independent channels.
- DLY_W, 6: width of each per-channel delay setting.
- DEPTH, 4: in-flight transitions per channel; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on each inR bit; legal range 0..3.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- inR  input  CH  two-phase requests; every level change is one event.
- dly_cfg  input  CH*DLY_W  delay setting D for channel i, held in bits [i*DLY_W +: DLY_W].
- outR  output  CH  delayed two-phase requests.
- busy  output  CH  high while channel i holds at least one pending event.
- ovf  output  CH  sticky flag: channel i dropped at least one event.
- ovf_clr  input  CH  clears ovf[i] on the next edge.

## Operation
- Clock and reset: one clock (clk). Reset (rst_n) is synchronous and active-low.
- Reset state, applied at the first edge with rst_n=0: outR=0, busy=0, ovf=0, synchroniser and edge-detect flops=0, all FIFOs empty, timestamp counter=0.
- Reset mid-operation discards every pending event. No outR toggle occurs on that edge.
- Timestamp counter:
  - Free-running, TS_W = DLY_W+$clog2(DEPTH)+2 bits, increments every cycle and wraps modulo 2^TS_W.
  - All time comparisons are wrap-aware: a is after b when (a-b) mod 2^TS_W is nonzero and below 2^(TS_W-1).
- Event detection: a channel has an event in a cycle when its synchroniser output differs from the registered previous value. There is at most one event per channel per cycle.
- Enqueue: on an event, dly_cfg[i] is sampled in the same cycle. Then:
  - Deff = max(D,1).
  - due = cnt+Deff.
  - If due is not after the tail entry's due, due = tail_due+1. Due times in a channel are therefore strictly increasing and never coincide.
- Changing dly_cfg affects only events enqueued after the change.
- Dequeue: when the head entry's due equals cnt, that edge pops the entry and inverts outR[i]. There is at most one toggle per channel per cycle.
- Full FIFO with an event and no pop in the same cycle: the event is dropped and ovf[i] is set. outR keeps its parity error until software recovers.
- Full FIFO with an event and a pop in the same cycle: both happen and nothing is dropped.
- ovf_clr[i] in the same cycle as a new overflow: set wins.
- busy[i] is the registered FIFO non-empty flag. It updates on the same edge as the push or pop.
- Channels are fully independent; each has its own FIFO pointers and count.

## Timing
- Edge 1 is the first rising edge at which a new inR level is sampled.
- The event is pushed at edge SYNC_STAGES+1.
- outR toggles at edge SYNC_STAGES+1+Deff, unless pushed later by the monotonic rule.
- Defaults (S=2, D=5): inR toggles before edge 1 and outR toggles at edge 8.
- busy rises at the push edge. It falls at the pop edge of the last entry.
- Minimum spacing of input events for lossless operation: none, provided at most DEPTH are pending at once.
- Output spacing of back-to-back events is one cycle minimum.

## Test plan
- Single event, defaults, D=5: toggle inR[0] once -> outR[0] toggles exactly at edge 8; busy[0] high from edge 3 to edge 8; other channels stay idle.
- D=0 and S=0: toggle inR[1] -> outR[1] toggles at edge 2, the same as D=1.
- Delay decrease with events in flight, channel 2:
  - Stimulus: event at D=20, then dly_cfg set to 2, then a second event 3 cycles later.
  - Required: the second toggle occurs one cycle after the first toggle, never before it.
- Overflow, DEPTH=4, D=63: six toggles on consecutive cycles -> 4 output toggles at 1-cycle spacing; ovf[3]=1 from the 5th event's push edge. ovf_clr pulsed in the same cycle as the 6th event leaves ovf=1.
- Full FIFO with simultaneous pop and push -> entry accepted and ovf stays 0.
- Reset mid-flight: pull rst_n low for 1 cycle with 3 events pending -> outR=0, busy=0, no later toggles.
- Timestamp wrap: run 2^TS_W-3 cycles, then apply an event with D=10 -> toggle 10+S+1 edges later. The result must be cycle-exact across the counter wrap.

Source files
------------

// File: rtl/toggle_delay_line.sv
// Programmable per-channel delay line for two-phase request channels.
// Each input transition is timestamped, queued, and replayed on outR when its due time arrives.
module toggle_delay_line #(
  parameter int CH          = 4,
  parameter int DLY_W       = 6,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH-1:0]         inR,
  input  logic [CH*DLY_W-1:0]   dly_cfg,
  output logic [CH-1:0]         outR,
  output logic [CH-1:0]         busy,
  output logic [CH-1:0]         ovf,
  input  logic [CH-1:0]         ovf_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int TS_W  = DLY_W + PTR_W + 2;

  // Wrap-aware ordering: a is after b when the modular distance is nonzero and in the lower half.
  function automatic logic ts_after(input logic [TS_W-1:0] a, input logic [TS_W-1:0] b);
    logic [TS_W-1:0] diff;
    diff = a - b;
    return (diff != {TS_W{1'b0}}) && !diff[TS_W-1];
  endfunction

  function automatic logic [TS_W-1:0] next_due(input logic [TS_W-1:0] now,
                                               input logic [DLY_W-1:0] d,
                                               input logic             has_tail,
                                               input logic [TS_W-1:0]  tail);
    logic [TS_W-1:0] base;
    if (d == {DLY_W{1'b0}}) begin
      base = now + TS_W'(1);
    end else begin
      base = now + TS_W'(d);
    end
    if (has_tail && !ts_after(base, tail)) begin
      return tail + TS_W'(1);
    end else begin
      return base;
    end
  endfunction

  logic [CH-1:0] sync_out;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = inR;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = inR;
        for (int s = 1; s < SYNC_STAGES; s++) begin
          sync_d[s] = sync_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [CH-1:0]                       prev_q, prev_d;
  logic [TS_W-1:0]                     cnt_q, cnt_d;
  logic [CH-1:0][DEPTH-1:0][TS_W-1:0]  mem_q, mem_d;
  logic [CH-1:0][PTR_W-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CH-1:0][OCC_W-1:0]            occ_q, occ_d;
  logic [CH-1:0][TS_W-1:0]             tail_q, tail_d;
  logic [CH-1:0]                       outr_q, outr_d, busy_q, busy_d, ovf_q, ovf_d;

  logic [CH-1:0]             ev_s, pop_s, push_s, drop_s;
  logic [CH-1:0][TS_W-1:0]   due_s;

  // Event detection, due-time computation and push/pop/drop decisions per channel.
  always_comb begin
    prev_d = sync_out;
    cnt_d  = cnt_q + TS_W'(1);
    ev_s   = sync_out ^ prev_q;
    pop_s  = '0;
    push_s = '0;
    drop_s = '0;
    due_s  = '0;
    for (int i = 0; i < CH; i++) begin
      due_s[i]  = next_due(cnt_q, dly_cfg[i*DLY_W +: DLY_W],
                           occ_q[i] != {OCC_W{1'b0}}, tail_q[i]);
      pop_s[i]  = (occ_q[i] != {OCC_W{1'b0}}) && (mem_q[i][rd_q[i]] == cnt_q);
      push_s[i] = ev_s[i] && ((occ_q[i] != OCC_W'(DEPTH)) || pop_s[i]);
      drop_s[i] = ev_s[i] && (occ_q[i] == OCC_W'(DEPTH)) && !pop_s[i];
    end
  end

  // FIFO, output and flag next-state; a pop frees its slot for a push on the same edge.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    occ_d  = occ_q;
    tail_d = tail_q;
    outr_d = outr_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < CH; i++) begin
      if (push_s[i]) begin
        mem_d[i][wr_q[i]] = due_s[i];
        wr_d[i]           = wr_q[i] + PTR_W'(1);
        tail_d[i]         = due_s[i];
      end else begin
        wr_d[i]   = wr_q[i];
        tail_d[i] = tail_q[i];
      end
      if (pop_s[i]) begin
        rd_d[i]   = rd_q[i] + PTR_W'(1);
        outr_d[i] = ~outr_q[i];
      end else begin
        rd_d[i]   = rd_q[i];
        outr_d[i] = outr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   occ_d[i] = occ_q[i] + OCC_W'(1);
        2'b01:   occ_d[i] = occ_q[i] - OCC_W'(1);
        default: occ_d[i] = occ_q[i];
      endcase
      busy_d[i] = (occ_d[i] != {OCC_W{1'b0}});
      ovf_d[i]  = drop_s[i] | (ovf_q[i] & ~ovf_clr[i]);
    end
  end

  // State registers; reset discards all pending events without toggling outR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      occ_q  <= '0;
      tail_q <= '0;
      outr_q <= '0;
      busy_q <= '0;
      ovf_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      occ_q  <= occ_d;
      tail_q <= tail_d;
      outr_q <= outr_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign outR = outr_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_toggle_delay_line.sv
// Scoreboard bench for toggle_delay_line: a default instance (two sync stages) and one with no synchroniser.
// Expected toggle edges are queued when stimulus is applied and retired by a per-cycle monitor.
module tb_toggle_delay_line;

  localparam int CH     = 4;
  localparam int DLY_W  = 6;
  localparam int DEPTH  = 4;
  localparam int S_MAIN = 2;
  localparam int TS_W   = DLY_W + $clog2(DEPTH) + 2;
  localparam int WRAP   = (1 << TS_W) - 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CH-1:0]       in_r = '0, in0_r = '0;
  logic [CH*DLY_W-1:0] cfg = '0, cfg0 = '0;
  logic [CH-1:0]       clr = '0, clr0 = '0;
  logic [CH-1:0]       outR, busy, ovf, outR0, busy0, ovf0;

  toggle_delay_line #(.CH(CH), .DLY_W(DLY_W), .DEPTH(DEPTH), .SYNC_STAGES(S_MAIN)) dut (
    .clk(clk), .rst_n(rst_n), .inR(in_r), .dly_cfg(cfg),
    .outR(outR), .busy(busy), .ovf(ovf), .ovf_clr(clr));

  toggle_delay_line #(.CH(CH), .DLY_W(DLY_W), .DEPTH(DEPTH), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .inR(in0_r), .dly_cfg(cfg0),
    .outR(outR0), .busy(busy0), .ovf(ovf0), .ovf_clr(clr0));

  always #5 clk = ~clk;

  typedef struct { int push; int out; } ev_t;

  ev_t           evq   [2*CH][$];
  int            dropq [2*CH][$];
  int            last_out [2*CH];
  logic [CH-1:0] exp_lvl [2];
  logic [CH-1:0] exp_ovf [2];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            rst_edge = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model one input transition: compute its push edge, output edge, or drop edge.
  task automatic toggle(input int u, input int ch, input int d);
    int   idx, p, o, pend;
    ev_t  e;
    idx  = u*CH + ch;
    p    = cyc + 1 + ((u == 0) ? S_MAIN : 0);
    o    = p + ((d == 0) ? 1 : d);
    if (last_out[idx] >= o) o = last_out[idx] + 1;
    pend = 0;
    for (int k = 0; k < evq[idx].size(); k++)
      if (evq[idx][k].out > p) pend++;
    if (pend >= DEPTH) begin
      dropq[idx].push_back(p);
    end else begin
      e.push = p;
      e.out  = o;
      evq[idx].push_back(e);
      last_out[idx] = o;
    end
    if (u == 0) begin
      in_r[ch] = ~in_r[ch];
      cfg[ch*DLY_W +: DLY_W] = DLY_W'(d);
    end else begin
      in0_r[ch] = ~in0_r[ch];
      cfg0[ch*DLY_W +: DLY_W] = DLY_W'(d);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: retire due entries, apply ovf set/clear, then compare every output once per cycle.
  always @(posedge clk) begin
    logic          rst_v;
    logic [CH-1:0] clr_v [2];
    logic [CH-1:0] eb;
    int            idx;
    cyc      = cyc + 1;
    rst_v    = rst_n;
    clr_v[0] = clr;
    clr_v[1] = clr0;
    #1;
    for (int u = 0; u < 2; u++) begin
      eb = '0;
      if (!rst_v) begin
        exp_lvl[u] = '0;
        exp_ovf[u] = '0;
      end
      for (int ch = 0; ch < CH; ch++) begin
        idx = u*CH + ch;
        if (!rst_v) begin
          evq[idx].delete();
          dropq[idx].delete();
          last_out[idx] = 0;
        end else begin
          while (evq[idx].size() > 0 && evq[idx][0].out == cyc) begin
            void'(evq[idx].pop_front());
            exp_lvl[u][ch] = ~exp_lvl[u][ch];
          end
          exp_ovf[u][ch] = exp_ovf[u][ch] & ~clr_v[u][ch];
          while (dropq[idx].size() > 0 && dropq[idx][0] == cyc) begin
            void'(dropq[idx].pop_front());
            exp_ovf[u][ch] = 1'b1;
          end
          for (int k = 0; k < evq[idx].size(); k++)
            if (evq[idx][k].push <= cyc) eb[ch] = 1'b1;
        end
      end
      if (u == 0) begin
        check_eq("outR", 32'(outR), 32'(exp_lvl[0]));
        check_eq("busy", 32'(busy), 32'(eb));
        check_eq("ovf",  32'(ovf),  32'(exp_ovf[0]));
      end else begin
        check_eq("outR_s0", 32'(outR0), 32'(exp_lvl[1]));
        check_eq("busy_s0", 32'(busy0), 32'(eb));
        check_eq("ovf_s0",  32'(ovf0),  32'(exp_ovf[1]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 2*CH; i++) last_out[i] = 0;
    exp_lvl[0] = '0; exp_lvl[1] = '0;
    exp_ovf[0] = '0; exp_ovf[1] = '0;

    // Reset state
    step(2);
    rst_n = 1'b1;

    // Single event with D=5 on channel 0
    toggle(0, 0, 5);
    step(12);

    // No synchroniser: D=0 behaves as D=1
    toggle(1, 1, 0);
    step(4);
    toggle(1, 1, 1);
    step(4);

    // Delay decrease with an event in flight on channel 2
    toggle(0, 2, 20);
    step(3);
    toggle(0, 2, 2);
    step(30);

    // Overflow on channel 3, with ovf_clr coinciding with the sixth event
    for (int i = 0; i < 6; i++) begin
      toggle(0, 3, 63);
      step(1);
    end
    step(1);
    clr[3] = 1'b1;
    step(1);
    clr = '0;
    step(80);
    clr[3] = 1'b1;
    step(1);
    clr = '0;
    step(3);

    // Full FIFO: push on the same edge as the first pop
    for (int i = 0; i < 4; i++) begin
      toggle(0, 3, 10);
      step(1);
    end
    step(6);
    toggle(0, 3, 10);
    step(30);

    // Reset with three events pending on channel 0
    for (int i = 0; i < 3; i++) begin
      toggle(0, 0, 30);
      step(1);
    end
    step(3);
    rst_n    = 1'b0;
    in_r     = '0;
    in0_r    = '0;
    rst_edge = cyc + 1;
    step(1);
    rst_n = 1'b1;
    step(40);

    // Timestamp wrap, including a monotonic adjustment across the wrap
    while (cyc < rst_edge + WRAP) step(1);
    toggle(0, 0, 10);
    toggle(0, 1, 10);
    step(3);
    toggle(0, 1, 1);
    step(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
